// File: rtl/jtframe_scan2x_pkg.sv
// jtframe_scan2x_pkg
// Shared types and helpers for the jtframe_scan2x_multi line doubler.
//   scan_mode_e : post-processing selector (plain, 50% / 25% scanlines, blend)
//   dim_chan()  : per-channel scanline dimming. The channel is passed
//                 zero-extended to CHAN_MAXW bits, so colour channels
//                 wider than CHAN_MAXW are not supported.
package jtframe_scan2x_pkg;

  typedef enum logic [1:0] {
    SCAN_PLAIN = 2'd0,
    SCAN_DIM50 = 2'd1,
    SCAN_DIM25 = 2'd2,
    SCAN_BLEND = 2'd3
  } scan_mode_e;

  localparam int CHAN_MAXW = 8;

  // Dims one colour channel on the second copy of a line. Blend is handled
  // elsewhere because it needs the previous pixel, so it passes through here.
  function automatic logic [CHAN_MAXW-1:0] dim_chan(
    input logic [CHAN_MAXW-1:0] c,
    input scan_mode_e           mode,
    input logic                 odd
  );
    logic [CHAN_MAXW-1:0] res;
    case (mode)
      SCAN_DIM50: res = odd ? (c >> 1'b1) : c;
      SCAN_DIM25: res = odd ? (c - (c >> 2'd2)) : c;
      default:    res = c;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/jtframe_scan2x_linebuf.sv
// jtframe_scan2x_linebuf
// Simple dual-port line buffer: one write port, one registered read port,
// single clock. The array has no reset so it can map onto block RAM.
//   clk     : system clock
//   we      : write enable
//   wr_addr : write address (bank bit on top)
//   wr_data : write data
//   rd_en   : read-register enable
//   rd_addr : read address (bank bit on top)
//   rd_data : registered read data (old data on a same-address collision)
module jtframe_scan2x_linebuf #(
  parameter int DW     = 12,
  parameter int ADDR_W = 10
)(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DW-1:0]     rd_data
);

  logic [DW-1:0] mem_r [0:(2**ADDR_W)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/jtframe_scan2x_multi.sv
// jtframe_scan2x_multi
// Line-doubling scan converter: each game line is written into one bank of a
// two-bank line buffer at base rate while the previous line is read out twice
// at double rate, with a regenerated double-rate horizontal sync and optional
// scanline / blend post-processing.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   base_cen    : base pixel clock enable
//   basex2_cen  : double-rate clock enable (coincides with every base_cen)
//   base_pxl    : game pixel {R,G,B}, sampled on base_cen
//   HS          : game horizontal sync, active high
//   mode        : 0 plain, 1 scanline 50%, 2 scanline 25%, 3 blend
//   x2_pxl      : doubled-rate pixel
//   x2_HS       : doubled-rate horizontal sync, active high
//   line_odd    : high while the second copy of a line is output
// Build option: define JTFRAME_SCAN2X_BLEND_EN to enable the mode 3 blend;
// without it mode 3 behaves as mode 0 and no blend logic is built.
// COLORW must not exceed jtframe_scan2x_pkg::CHAN_MAXW.
module jtframe_scan2x_multi
  import jtframe_scan2x_pkg::*;
#(
  parameter int COLORW = 4,
  parameter int HLEN   = 384,
  parameter int HSW    = 32,
  parameter int AW     = 9
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                base_cen,
  input  logic                basex2_cen,
  input  logic [3*COLORW-1:0] base_pxl,
  input  logic                HS,
  input  logic [1:0]          mode,
  output logic [3*COLORW-1:0] x2_pxl,
  output logic                x2_HS,
  output logic                line_odd
);

  localparam int DW   = 3*COLORW;
  localparam int CNTW = $clog2(HSW+1);
  localparam logic [AW-1:0]   ADDR_LAST = AW'(HLEN-1);
  localparam logic [CNTW-1:0] HS_LAST   = CNTW'(HSW-1);

  logic            hs_r;
  logic            line_start_s;
  logic [AW-1:0]   wr_addr_r;
  logic            bank_r;
  logic [AW:0]     wr_sel_s;
  logic [AW-1:0]   rd_addr_r;
  logic            odd_r;
  logic            rd_wrap_s;
  logic            rl_start_s;
  scan_mode_e      mode_r;
  logic [CNTW-1:0] hs_cnt_r;
  logic            hs_raw_r;
  logic [DW-1:0]   ram_q_s;
  logic            odd_d_r;
  scan_mode_e      mode_d_r;
  logic            hs_d_r;
  logic [DW-1:0]   proc_s;
`ifdef JTFRAME_SCAN2X_BLEND_EN
  logic [DW-1:0]   prev_r;
`endif

  // Applies scanline dimming to all three channels of a pixel
  function automatic logic [DW-1:0] dim_pxl(
    input logic [DW-1:0] pxl,
    input scan_mode_e    m,
    input logic          odd
  );
    logic [DW-1:0] res;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      res[ch*COLORW +: COLORW] =
        COLORW'(dim_chan(CHAN_MAXW'(pxl[ch*COLORW +: COLORW]), m, odd));
    end
    return res;
  endfunction

`ifdef JTFRAME_SCAN2X_BLEND_EN
  // Rounded average of two pixels, per channel, with one guard bit
  function automatic logic [DW-1:0] blend_pxl(
    input logic [DW-1:0] cur,
    input logic [DW-1:0] prev
  );
    logic [DW-1:0]   res;
    logic [COLORW:0] sum;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum = (COLORW+1)'(cur[ch*COLORW +: COLORW])
          + (COLORW+1)'(prev[ch*COLORW +: COLORW])
          + {{COLORW{1'b0}}, 1'b1};
      res[ch*COLORW +: COLORW] = COLORW'(sum >> 1'b1);
    end
    return res;
  endfunction
`endif

  assign line_start_s = base_cen & HS & ~hs_r;
  assign rd_wrap_s    = basex2_cen & (rd_addr_r == ADDR_LAST);
  assign rl_start_s   = line_start_s | rd_wrap_s;

  // The pixel that carries the HS edge is pixel 0 of the new line, so it
  // goes straight to address 0 of the freshly selected bank.
  assign wr_sel_s = line_start_s ? {~bank_r, {AW{1'b0}}} : {bank_r, wr_addr_r};

  // HS sampled at base rate for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_r <= 1'b0;
    end else if (base_cen) begin
      hs_r <= HS;
    end
  end

  // Write address and bank; address saturates so long lines stay in their bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_r <= '0;
      bank_r    <= 1'b0;
    end else if (line_start_s) begin
      wr_addr_r <= AW'(1);
      bank_r    <= ~bank_r;
    end else if (base_cen && (wr_addr_r != ADDR_LAST)) begin
      wr_addr_r <= wr_addr_r + 1'b1;
    end
  end

  // Read address and copy parity; an input line start overrides the wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_r <= '0;
      odd_r     <= 1'b0;
    end else if (line_start_s) begin
      rd_addr_r <= '0;
      odd_r     <= 1'b0;
    end else if (rd_wrap_s) begin
      rd_addr_r <= '0;
      odd_r     <= ~odd_r;
    end else if (basex2_cen) begin
      rd_addr_r <= rd_addr_r + 1'b1;
    end
  end

  // Mode is latched once per output line so a line never changes style midway
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= SCAN_PLAIN;
    end else if (rl_start_s) begin
      mode_r <= scan_mode_e'(mode);
    end
  end

  // Undelayed x2 sync pulse, HSW ticks long, restarted by every output line start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_raw_r <= 1'b0;
      hs_cnt_r <= '0;
    end else if (rl_start_s) begin
      hs_raw_r <= 1'b1;
      hs_cnt_r <= '0;
    end else if (basex2_cen && hs_raw_r) begin
      if (hs_cnt_r == HS_LAST) begin
        hs_raw_r <= 1'b0;
      end else begin
        hs_cnt_r <= hs_cnt_r + 1'b1;
      end
    end
  end

  jtframe_scan2x_linebuf #(
    .DW     (DW),
    .ADDR_W (AW+1)
  ) u_linebuf (
    .clk     (clk),
    .we      (base_cen),
    .wr_addr (wr_sel_s),
    .wr_data (base_pxl),
    .rd_en   (basex2_cen),
    .rd_addr ({~bank_r, rd_addr_r}),
    .rd_data (ram_q_s)
  );

  // Side-band signals follow the RAM read stage so they line up with ram_q_s
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odd_d_r  <= 1'b0;
      mode_d_r <= SCAN_PLAIN;
      hs_d_r   <= 1'b0;
    end else if (basex2_cen) begin
      odd_d_r  <= odd_r;
      mode_d_r <= mode_r;
      hs_d_r   <= hs_raw_r;
    end
  end

`ifdef JTFRAME_SCAN2X_BLEND_EN
  // Previous pixel read, for the horizontal blend
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= '0;
    end else if (basex2_cen) begin
      prev_r <= ram_q_s;
    end
  end
`endif

  // Final-stage pixel processing
  always_comb begin
    proc_s = '0;
`ifdef JTFRAME_SCAN2X_BLEND_EN
    if (mode_d_r == SCAN_BLEND) begin
      proc_s = blend_pxl(ram_q_s, prev_r);
    end else begin
      proc_s = dim_pxl(ram_q_s, mode_d_r, odd_d_r);
    end
`else
    proc_s = dim_pxl(ram_q_s, mode_d_r, odd_d_r);
`endif
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x2_pxl   <= '0;
      x2_HS    <= 1'b0;
      line_odd <= 1'b0;
    end else if (basex2_cen) begin
      x2_pxl   <= proc_s;
      x2_HS    <= hs_d_r;
      line_odd <= odd_d_r;
    end
  end

endmodule

// File: tb/tb_jtframe_scan2x_multi.sv
// tb_jtframe_scan2x_multi
// Self-checking bench for jtframe_scan2x_multi. Pixels are randomised or
// patterned per line; a line-level reference model predicts every doubled
// output tick (pixel, x2_HS, line_odd) from the input lines.
module tb_jtframe_scan2x_multi;

  localparam int CW   = 4;
  localparam int DW   = 3*CW;
  localparam int HL   = 384;
  localparam int HSWP = 32;
  localparam int AWP  = 9;
  localparam int HS_PIXELS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          base_cen = 1'b0;
  logic          basex2_cen = 1'b0;
  logic [DW-1:0] base_pxl = '0;
  logic          HS = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] x2_pxl;
  logic          x2_HS;
  logic          line_odd;

  int errors = 0;
  int checks = 0;

  jtframe_scan2x_multi #(
    .COLORW (CW),
    .HLEN   (HL),
    .HSW    (HSWP),
    .AW     (AWP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .base_cen   (base_cen),
    .basex2_cen (basex2_cen),
    .base_pxl   (base_pxl),
    .HS         (HS),
    .mode       (mode),
    .x2_pxl     (x2_pxl),
    .x2_HS      (x2_HS),
    .line_odd   (line_odd)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit            v;
    logic [DW-1:0] px;
    bit            hs;
    bit            odd;
  } ent_t;

  logic [DW-1:0] cur_line  [HL];
  logic [DW-1:0] prev_line [HL];
  int   cur_cnt, prev_len, t_rd, since_rl, mode_cur;
  bit   cur_full, prev_full, hs_prev, rl_seen, last_rv;
  logic [DW-1:0] last_raw;
  ent_t pipe[$];
  ent_t exp_e;

`ifdef JTFRAME_SCAN2X_BLEND_EN
  localparam bit BLEND_ON = 1'b1;
`else
  localparam bit BLEND_ON = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_proc(input logic [DW-1:0] raw, input logic [DW-1:0] prv,
                                             input int m, input bit odd);
    logic [DW-1:0] res;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      int c, p, o;
      c = int'(raw[CW*ch +: CW]);
      p = int'(prv[CW*ch +: CW]);
      if (m == 1)                 o = odd ? c / 2 : c;
      else if (m == 2)            o = odd ? c - c / 4 : c;
      else if (m == 3 && BLEND_ON) o = (c + p + 1) / 2;
      else                        o = c;
      res[CW*ch +: CW] = o[CW-1:0];
    end
    return res;
  endfunction

  task automatic model_reset();
    ent_t z;
    t_rd = 0; since_rl = 0; rl_seen = 0; mode_cur = 0; hs_prev = 0;
    cur_cnt = 0; prev_len = 0; cur_full = 0; prev_full = 0;
    last_rv = 0; last_raw = '0;
    z.v = 0; z.px = '0; z.hs = 0; z.odd = 0;
    pipe.delete();
    pipe.push_back(z);
    pipe.push_back(z);
  endtask

  // One double-rate tick: advance the line model and produce the value the
  // outputs must show after this edge (two ticks of read latency).
  task automatic model_tick(input bit is_base, input bit hs_in, input logic [DW-1:0] px_in, input int m_in);
    bit ls, rl, rv, odd;
    int pos;
    logic [DW-1:0] raw;
    ent_t e;
    ls = 0;
    if (is_base) begin
      ls = hs_in && !hs_prev;
      hs_prev = hs_in;
      if (ls) begin
        prev_line = cur_line;
        prev_len  = (cur_cnt > HL) ? HL : cur_cnt;
        prev_full = cur_full;
        cur_full  = 1;
        cur_line[0] = px_in;
        cur_cnt = 1;
      end else begin
        cur_line[(cur_cnt < HL) ? cur_cnt : HL-1] = px_in;
        cur_cnt++;
      end
    end
    if (ls) t_rd = 0; else t_rd++;
    pos = t_rd % HL;
    odd = ((t_rd / HL) % 2) == 1;
    rl  = ls || (pos == 0 && t_rd > 0);
    if (rl) begin
      mode_cur = m_in; since_rl = 0; rl_seen = 1;
    end else if (since_rl < 100000) begin
      since_rl++;
    end
    raw = prev_line[pos];
    rv  = prev_full && (pos < prev_len);
    e.v   = rv && !(BLEND_ON && mode_cur == 3 && !last_rv);
    e.px  = exp_proc(raw, last_raw, mode_cur, odd);
    e.hs  = rl_seen && (since_rl < HSWP);
    e.odd = odd;
    last_raw = raw;
    last_rv  = rv;
    pipe.push_back(e);
    exp_e = pipe.pop_front();
  endtask

  // ---------------- stimulus ----------------
  task automatic step(input bit b, input bit x2, input bit hs_in, input logic [DW-1:0] px);
    @(negedge clk);
    base_cen = b; basex2_cen = x2; HS = hs_in; base_pxl = px;
    if (x2) model_tick(b, hs_in, px, int'(mode));
    @(posedge clk);
    #1;
    if (x2) begin
      check_eq("x2_HS", {31'd0, x2_HS}, {31'd0, exp_e.hs});
      check_eq("line_odd", {31'd0, line_odd}, {31'd0, exp_e.odd});
      if (exp_e.v) check_eq("x2_pxl", {20'd0, x2_pxl}, {20'd0, exp_e.px});
    end
  endtask

  task automatic send_pixel(input bit hs_in, input logic [DW-1:0] px);
    step(1'b1, 1'b1, hs_in, px);
    step(1'b0, 1'b0, hs_in, px);
    step(1'b0, 1'b1, hs_in, px);
    step(1'b0, 1'b0, hs_in, px);
  endtask

  // pat: 0 pixel index, 1 all-ones, 2 8C4, 3 alternating 000/FFF, else random
  task automatic send_line(input int len, input int pat, input int m);
    logic [DW-1:0] px;
    mode = m[1:0];
    for (int j = 0; j < len; j++) begin
      case (pat)
        0:       px = DW'(j);
        1:       px = 12'hFFF;
        2:       px = 12'h8C4;
        3:       px = (j % 2 == 1) ? 12'hFFF : 12'h000;
        default: px = DW'($urandom);
      endcase
      send_pixel(j < HS_PIXELS, px);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_x2_pxl"}, {20'd0, x2_pxl}, 32'd0);
    check_eq({tag, "_x2_HS"}, {31'd0, x2_HS}, 32'd0);
    check_eq({tag, "_line_odd"}, {31'd0, line_odd}, 32'd0);
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3) send_line(HL, 0, 0);
    repeat (2) send_line(HL, 1, 1);
    repeat (2) send_line(HL, 2, 2);
    repeat (2) send_line(HL, 3, 3);
    repeat (2) send_line(300, 4, 0);
    repeat (2) send_line(400, 4, 1);
    send_line(HL, 4, 2);

    // partial line, then an asynchronous reset pulse mid-line
    mode = 2'd1;
    for (int j = 0; j < 200; j++) send_pixel(j < HS_PIXELS, DW'($urandom));
    @(negedge clk);
    base_cen = 1'b0; basex2_cen = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    send_line(HL, 0, 0);
    send_line(HL, 4, int'($urandom_range(0, 3)));
    send_line(HL, 0, 0);
    send_line(HL, 4, int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within its time budget");
    $fatal(1, "timeout");
  end

endmodule
